// File: rtl/vram_split_sam.sv
// vram_split_sam: dual-port video RAM with a serial access memory (SAM).
// The host side is a RAS/CAS strobed word port. The serial side is a one-row
// shift register clocked by SC. Rows move between the RAM and the SAM in BEAT-wide
// beats, either as a whole row or, for split transfers, as the idle half only.
module vram_split_sam #(
    parameter int ROW_W = 8,
    parameter int COL_W = 8,
    parameter int SW    = 8,
    parameter int BEAT  = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [ROW_W+COL_W-1:0] A,
    input  logic [2*SW-1:0]        D,
    output logic [2*SW-1:0]        Q,
    input  logic                   RAS_N,
    input  logic [1:0]             CAS_N,
    input  logic                   WE_N,
    input  logic                   OE_N,
    input  logic                   DSF,
    output logic                   RDY,
    input  logic                   SC,
    input  logic                   SE_N,
    input  logic [SW-1:0]          SD,
    output logic [SW-1:0]          SQ,
    output logic                   QSF
);

    localparam int NCOL  = 1 << COL_W;
    localparam int DEPTH = (1 << ROW_W) * NCOL;

    localparam logic [COL_W-1:0] BEAT_C    = COL_W'(BEAT);
    localparam logic [COL_W-1:0] LAST_FULL = COL_W'(NCOL - BEAT);
    localparam logic [COL_W-2:0] LAST_HALF = (COL_W-1)'(NCOL/2 - BEAT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        XFER_FULL = 2'd1,
        XFER_HALF = 2'd2
    } state_t;

    // Storage: the RAM is flat, indexed by {row, column}; the SAM holds one row.
    logic [SW-1:0] mem [DEPTH];
    logic [SW-1:0] sam [NCOL];

    // Edge-detect history and transfer control
    logic              ras_q, sc_q, we_q;
    state_t            state;
    logic              rdy;
    logic [COL_W-1:0]  cnt;
    logic [ROW_W-1:0]  xrow;
    logic              xfer_to_mem;
    logic              xfer_en;

    // Serial-side state
    logic [COL_W-1:0]       ptr;
    logic [1:0][COL_W-1:0]  stored_tap;
    logic                   sam_in;
    logic                   split;

    // Decoded strobes
    logic             ras_fall, sc_rise, we_fall;
    logic             cyc_frt, cyc_srt, cyc_wt, host_wr;
    logic             sc_ok, last_beat, xfer_active;
    logic [ROW_W-1:0] a_row;
    logic [COL_W-1:0] a_col;
    logic [COL_W-1:0] ptr_adv;

    assign a_row = A[ROW_W+COL_W-1:COL_W];
    assign a_col = A[COL_W-1:0];

    assign ras_fall = ras_q & ~RAS_N;
    assign sc_rise  = SC & ~sc_q;
    assign we_fall  = we_q & ~WE_N;

    // Transfer cycles are only accepted while idle; falls during a transfer are lost.
    assign cyc_frt = ras_fall & rdy & ~OE_N &  WE_N & ~DSF;
    assign cyc_srt = ras_fall & rdy & ~OE_N &  WE_N &  DSF;
    assign cyc_wt  = ras_fall & rdy & ~OE_N & ~WE_N;
    assign host_wr = we_fall & ~RAS_N & OE_N;

    // During a full transfer the SAM is being reloaded, so the shifter is frozen.
    // During a half transfer the other half keeps shifting.
    assign sc_ok       = sc_rise & (state != XFER_FULL);
    assign xfer_active = (state != IDLE) & xfer_en;

    assign last_beat = (state == XFER_HALF) ? (cnt[COL_W-2:0] == LAST_HALF)
                                            : (cnt == LAST_FULL);

    // In split output mode the end of a half jumps to the tap stored for the other half.
    assign ptr_adv = (!sam_in && split && (&ptr[COL_W-2:0])) ? stored_tap[~ptr[COL_W-1]]
                                                             : ptr + 1'b1;

    assign RDY = rdy;
    assign QSF = ptr[COL_W-1];
    assign SQ  = sam[ptr];

    // Strobe history for edge detection
    always_ff @(posedge CLK) begin
        if (RST) begin
            ras_q <= 1'b0;
            sc_q  <= 1'b0;
            we_q  <= 1'b0;
        end else begin
            ras_q <= RAS_N;
            sc_q  <= SC;
            we_q  <= WE_N;
        end
    end

    // Transfer sequencer: decode at the RAS fall, then walk the row BEAT units per cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            rdy         <= 1'b1;
            cnt         <= '0;
            xrow        <= '0;
            xfer_to_mem <= 1'b0;
            xfer_en     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cyc_frt || cyc_wt) begin
                        state       <= XFER_FULL;
                        rdy         <= 1'b0;
                        cnt         <= '0;
                        xrow        <= a_row;
                        xfer_to_mem <= cyc_wt;
                        // a write transfer with SE_N high is a pseudo-write: mode change only
                        xfer_en     <= cyc_frt | ~SE_N;
                    end else if (cyc_srt) begin
                        state       <= XFER_HALF;
                        rdy         <= 1'b0;
                        cnt         <= {~QSF, {(COL_W-1){1'b0}}};
                        xrow        <= a_row;
                        xfer_to_mem <= 1'b0;
                        xfer_en     <= 1'b1;
                    end
                end
                XFER_FULL, XFER_HALF: begin
                    cnt <= cnt + BEAT_C;
                    if (last_beat) begin
                        state <= IDLE;
                        rdy   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                end
            endcase
        end
    end

    // Serial pointer, stored split taps and SAM direction/mode
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr        <= '0;
            stored_tap <= '0;
            sam_in     <= 1'b0;
            split      <= 1'b0;
        end else begin
            if (cyc_frt || cyc_wt)
                ptr <= a_col;
            else if (sc_ok)
                ptr <= ptr_adv;

            if (cyc_frt) begin
                sam_in <= 1'b0;
                split  <= 1'b0;
            end else if (cyc_wt) begin
                sam_in <= 1'b1;
                split  <= 1'b0;
            end else if (cyc_srt) begin
                sam_in <= 1'b0;
                split  <= 1'b1;
                stored_tap[~QSF] <= {~QSF, a_col[COL_W-2:0]};
            end
        end
    end

    // Host read port: one-cycle registered word read at the current address
    always_ff @(posedge CLK) begin
        if (RST)
            Q <= '0;
        else
            Q <= {mem[{a_row, a_col[COL_W-1:1], 1'b1}], mem[{a_row, a_col[COL_W-1:1], 1'b0}]};
    end

    // RAM writes: write-transfer beats and byte-lane host writes (contents survive reset)
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (xfer_active && xfer_to_mem) begin
                for (int i = 0; i < BEAT; i++)
                    mem[{xrow, cnt + COL_W'(i)}] <= sam[cnt + COL_W'(i)];
            end
            if (host_wr) begin
                for (int l = 0; l < 2; l++)
                    if (!CAS_N[l])
                        mem[{a_row, a_col[COL_W-1:1], 1'(l)}] <= D[l*SW +: SW];
            end
        end
    end

    // SAM writes: read-transfer beats and serial input shifting (contents survive reset)
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (xfer_active && !xfer_to_mem) begin
                for (int i = 0; i < BEAT; i++)
                    sam[cnt + COL_W'(i)] <= mem[{xrow, cnt + COL_W'(i)}];
            end
            if (sc_ok && sam_in && !SE_N)
                sam[ptr] <= SD;
        end
    end

endmodule

// File: tb/tb_vram_split_sam.sv
// Directed bench for vram_split_sam: host port, full/split read transfers,
// serial input with write transfer, busy-time boundaries and mid-transfer reset.
module tb_vram_split_sam;

    localparam int ROW_W = 8;
    localparam int COL_W = 8;
    localparam int SW    = 8;
    localparam int BEAT  = 8;

    logic                   CLK, RST;
    logic [ROW_W+COL_W-1:0] A;
    logic [2*SW-1:0]        D, Q;
    logic                   RAS_N, WE_N, OE_N, DSF, RDY, SC, SE_N, QSF;
    logic [1:0]             CAS_N;
    logic [SW-1:0]          SD, SQ;

    int tests = 0;
    int fails = 0;

    vram_split_sam #(.ROW_W(ROW_W), .COL_W(COL_W), .SW(SW), .BEAT(BEAT)) dut (
        .CLK(CLK), .RST(RST), .A(A), .D(D), .Q(Q),
        .RAS_N(RAS_N), .CAS_N(CAS_N), .WE_N(WE_N), .OE_N(OE_N), .DSF(DSF),
        .RDY(RDY), .SC(SC), .SE_N(SE_N), .SD(SD), .SQ(SQ), .QSF(QSF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic host_write(input logic [7:0] row, input logic [7:0] col,
                              input logic [15:0] data, input logic [1:0] cas);
        A = {row, col}; OE_N = 1'b1; WE_N = 1'b1; RAS_N = 1'b0;
        tick();
        CAS_N = cas; D = data; WE_N = 1'b0;
        tick();
        WE_N = 1'b1; RAS_N = 1'b1; CAS_N = 2'b11;
        tick();
    endtask

    task automatic host_read(input logic [7:0] row, input logic [7:0] col);
        A = {row, col};
        tick();
    endtask

    task automatic fill_row(input logic [7:0] row, input logic [7:0] xv);
        for (int c = 0; c < 256; c += 2)
            host_write(row, 8'(c), {8'(c + 1) ^ xv, 8'(c) ^ xv}, 2'b00);
    endtask

    task automatic start_xfer(input logic [7:0] row, input logic [7:0] tap,
                              input logic oe, input logic we, input logic dsf, input logic se);
        A = {row, tap}; OE_N = oe; WE_N = we; DSF = dsf; SE_N = se; RAS_N = 1'b0;
        tick();
        RAS_N = 1'b1; OE_N = 1'b1; WE_N = 1'b1; DSF = 1'b0; SE_N = 1'b1;
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        while (RDY !== 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic sc_pulse();
        SC = 1'b1;
        tick();
        SC = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(); tick();
        tests++; if (RDY !== 1'b1) begin fails++; $display("FAIL reset_rdy: got %b expected 1", RDY); end
        tests++; if (Q !== 16'h0000) begin fails++; $display("FAIL reset_q: got %h expected 0000", Q); end
        tests++; if (QSF !== 1'b0) begin fails++; $display("FAIL reset_qsf: got %b expected 0", QSF); end
        RST = 1'b0;
        tick(); tick();
    endtask

    task automatic test_host();
        host_write(8'd3, 8'h10, 16'hA55A, 2'b00);
        host_write(8'd3, 8'h10, 16'hFF11, 2'b10);
        host_read(8'd3, 8'h10);
        tests++; if (Q !== 16'hA511) begin fails++; $display("FAIL host_lane_write: got %h expected a511", Q); end
        host_read(8'd3, 8'h11);
        tests++; if (Q !== 16'hA511) begin fails++; $display("FAIL host_col_bit0: got %h expected a511", Q); end
    endtask

    task automatic test_frt();
        int n;
        logic [7:0] exp_sq [6];
        logic       exp_qsf [6];
        exp_sq  = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
        exp_qsf = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        fill_row(8'd5, 8'h00);
        start_xfer(8'd5, 8'hFC, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_rdy(n);
        tests++; if (n != 32) begin fails++; $display("FAIL frt_busy: got %0d cycles expected 32", n); end
        for (int k = 0; k < 6; k++) begin
            tests++;
            if (SQ !== exp_sq[k] || QSF !== exp_qsf[k]) begin
                fails++;
                $display("FAIL frt_shift[%0d]: got sq=%h qsf=%b expected sq=%h qsf=%b", k, SQ, QSF, exp_sq[k], exp_qsf[k]);
            end
            sc_pulse();
        end
    endtask

    task automatic test_busy_boundary();
        int n;
        start_xfer(8'd5, 8'h40, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (3) sc_pulse();
        A = {8'd1, 8'h80}; OE_N = 1'b0; RAS_N = 1'b0;
        tick();
        RAS_N = 1'b1; OE_N = 1'b1;
        tick();
        tests++; if (RDY !== 1'b0) begin fails++; $display("FAIL busy_rdy: got %b expected 0", RDY); end
        wait_rdy(n);
        tests++; if (n != 24) begin fails++; $display("FAIL busy_ignored_ras: got %0d remaining cycles expected 24", n); end
        tests++; if (SQ !== 8'h40 || QSF !== 1'b0) begin fails++; $display("FAIL busy_sc_dropped: got sq=%h qsf=%b expected sq=40 qsf=0", SQ, QSF); end
    endtask

    task automatic test_srt();
        int n;
        fill_row(8'd1, 8'h11);
        fill_row(8'd2, 8'h22);
        start_xfer(8'd1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_rdy(n);
        tests++; if (SQ !== 8'h11) begin fails++; $display("FAIL srt_frt_base: got %h expected 11", SQ); end
        repeat (16) sc_pulse();
        tests++; if (SQ !== 8'h01) begin fails++; $display("FAIL srt_pre_shift: got %h expected 01", SQ); end
        start_xfer(8'd2, 8'h90, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (2) sc_pulse();
        tests++; if (SQ !== 8'h03 || RDY !== 1'b0) begin fails++; $display("FAIL srt_shift_during: got sq=%h rdy=%b expected sq=03 rdy=0", SQ, RDY); end
        wait_rdy(n);
        tests++; if (n != 12) begin fails++; $display("FAIL srt_busy: got %0d remaining cycles expected 12", n); end
        repeat (8'h6D) sc_pulse();
        tests++; if (SQ !== 8'h6E || QSF !== 1'b0) begin fails++; $display("FAIL srt_at_7f: got sq=%h qsf=%b expected sq=6e qsf=0", SQ, QSF); end
        sc_pulse();
        tests++; if (SQ !== 8'hB2 || QSF !== 1'b1) begin fails++; $display("FAIL srt_jump_90: got sq=%h qsf=%b expected sq=b2 qsf=1", SQ, QSF); end
        repeat (8'h6F) sc_pulse();
        tests++; if (SQ !== 8'hDD) begin fails++; $display("FAIL srt_at_ff: got %h expected dd", SQ); end
        sc_pulse();
        tests++; if (SQ !== 8'h11 || QSF !== 1'b0) begin fails++; $display("FAIL srt_lower_kept: got sq=%h qsf=%b expected sq=11 qsf=0", SQ, QSF); end
    endtask

    task automatic test_serial_wt();
        int n;
        host_write(8'd7, 8'h40, 16'h1234, 2'b00);
        start_xfer(8'd7, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_rdy(n);
        tests++; if (n != 32) begin fails++; $display("FAIL wt_pseudo_busy: got %0d cycles expected 32", n); end
        host_read(8'd7, 8'h40);
        tests++; if (Q !== 16'h1234) begin fails++; $display("FAIL wt_pseudo_nowrite: got %h expected 1234", Q); end
        SE_N = 1'b0;
        for (int i = 0; i < 256; i++) begin
            SD = ~8'(i);
            sc_pulse();
        end
        SE_N = 1'b1;
        start_xfer(8'd7, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_rdy(n);
        tests++; if (n != 32) begin fails++; $display("FAIL wt_busy: got %0d cycles expected 32", n); end
        host_read(8'd7, 8'h00);
        tests++; if (Q !== 16'hFEFF) begin fails++; $display("FAIL wt_row7_00: got %h expected feff", Q); end
        host_read(8'd7, 8'h22);
        tests++; if (Q !== 16'hDCDD) begin fails++; $display("FAIL wt_row7_22: got %h expected dcdd", Q); end
        host_read(8'd7, 8'h40);
        tests++; if (Q !== 16'hBEBF) begin fails++; $display("FAIL wt_row7_40: got %h expected bebf", Q); end
        host_read(8'd7, 8'hFE);
        tests++; if (Q !== 16'h0001) begin fails++; $display("FAIL wt_row7_fe: got %h expected 0001", Q); end
    endtask

    task automatic test_reset_mid_xfer();
        int n;
        start_xfer(8'd5, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (9) tick();
        RST = 1'b1;
        tick();
        tests++; if (RDY !== 1'b1 || QSF !== 1'b0) begin fails++; $display("FAIL rst_abort: got rdy=%b qsf=%b expected rdy=1 qsf=0", RDY, QSF); end
        tests++; if (SQ !== 8'h00 || Q !== 16'h0000) begin fails++; $display("FAIL rst_ptr0: got sq=%h q=%h expected sq=00 q=0000", SQ, Q); end
        RST = 1'b0;
        tick(); tick();
        start_xfer(8'd5, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_rdy(n);
        tests++; if (n != 32) begin fails++; $display("FAIL rst_next_busy: got %0d cycles expected 32", n); end
        tests++; if (SQ !== 8'h33 || QSF !== 1'b0) begin fails++; $display("FAIL rst_next_frt: got sq=%h qsf=%b expected sq=33 qsf=0", SQ, QSF); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; A = '0; D = '0; RAS_N = 1'b1; CAS_N = 2'b11; WE_N = 1'b1;
        OE_N = 1'b1; DSF = 1'b0; SC = 1'b0; SE_N = 1'b1; SD = '0;
        test_reset();
        test_host();
        test_frt();
        test_busy_boundary();
        test_srt();
        test_serial_wt();
        test_reset_mid_xfer();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
